// File: rtl/pc_sp_unit.sv
// Program-counter / stack-pointer unit: next-PC selection plus a stack pointer
// whose CALL/PUSH/POP traffic goes through a req/ack memory handshake.
module pc_sp_unit #(
  parameter int unsigned            DATA_WIDTH  = 32,
  parameter int unsigned            ADDR_WIDTH  = 26,
  parameter logic [DATA_WIDTH-1:0]  RESET_PC    = 32'h0000_1000,
  parameter logic [DATA_WIDTH-1:0]  RESET_SP    = 32'h03FF_FFFF,
  parameter logic [DATA_WIDTH-1:0]  STACK_LIMIT = 32'h03FF_0000
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [2:0]            CMD_OP,
  input  logic [DATA_WIDTH-1:0] IMM,
  input  logic [DATA_WIDTH-1:0] REG_VAL,
  input  logic                  ZERO,
  output logic [DATA_WIDTH-1:0] PC,
  output logic [DATA_WIDTH-1:0] SP,
  output logic                  MEM_REQ,
  output logic                  MEM_WE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_WDATA,
  input  logic [DATA_WIDTH-1:0] MEM_RDATA,
  input  logic                  MEM_ACK,
  output logic [DATA_WIDTH-1:0] POP_DATA,
  output logic                  POP_VALID,
  output logic                  STK_ERR
);

  typedef enum logic {S_IDLE, S_MEM_WAIT} state_e;
  typedef enum logic [2:0] {
    OP_NOP, OP_BEQ, OP_BNE, OP_JMP, OP_JR, OP_CALL, OP_PUSH, OP_POP
  } op_e;

  state_e                  state_q, state_d;
  op_e                     pend_q, pend_d;
  logic [DATA_WIDTH-1:0]   pc_q, pc_d;
  logic [DATA_WIDTH-1:0]   sp_q, sp_d;
  logic [DATA_WIDTH-1:0]   tgt_q, tgt_d;
  logic                    mem_req_q, mem_req_d;
  logic                    mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [DATA_WIDTH-1:0]   pop_data_q, pop_data_d;
  logic                    pop_valid_q, pop_valid_d;
  logic                    stk_err_q, stk_err_d;

  logic [DATA_WIDTH-1:0]   pc1, jmp_tgt, sp_inc, sp_dec;
  logic                    accept, overflow, underflow;
  op_e                     op;

  assign CMD_READY = (state_q == S_IDLE) & RST;

  always_comb begin
    pc1       = pc_q + 1'b1;
    jmp_tgt   = {pc1[DATA_WIDTH-1:ADDR_WIDTH], IMM[ADDR_WIDTH-1:0]};
    sp_inc    = sp_q + 1'b1;
    sp_dec    = sp_q - 1'b1;
    accept    = CMD_VALID & CMD_READY;
    overflow  = sp_q < STACK_LIMIT;
    underflow = sp_q == RESET_SP;
    op        = op_e'(CMD_OP);

    state_d     = state_q;
    pend_d      = pend_q;
    pc_d        = pc_q;
    sp_d        = sp_q;
    tgt_d       = tgt_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    pop_data_d  = pop_data_q;
    pop_valid_d = 1'b0;
    stk_err_d   = stk_err_q;

    if (state_q == S_IDLE) begin
      if (accept) begin
        case (op)
          OP_NOP: pc_d = pc1;
          OP_BEQ: pc_d = ZERO ? pc1 + IMM : pc1;
          OP_BNE: pc_d = !ZERO ? pc1 + IMM : pc1;
          OP_JMP: pc_d = jmp_tgt;
          OP_JR:  pc_d = REG_VAL;
          OP_CALL, OP_PUSH: begin
            // Full stack: the op retires immediately as a flagged no-op.
            if (overflow) begin
              stk_err_d = 1'b1;
              pc_d      = pc1;
            end else begin
              state_d     = S_MEM_WAIT;
              pend_d      = op;
              mem_req_d   = 1'b1;
              mem_we_d    = 1'b1;
              mem_addr_d  = sp_q[ADDR_WIDTH-1:0];
              mem_wdata_d = (op == OP_CALL) ? pc1 : REG_VAL;
              tgt_d       = jmp_tgt;
            end
          end
          OP_POP: begin
            if (underflow) begin
              stk_err_d = 1'b1;
              pc_d      = pc1;
            end else begin
              state_d    = S_MEM_WAIT;
              pend_d     = op;
              mem_req_d  = 1'b1;
              mem_we_d   = 1'b0;
              mem_addr_d = sp_inc[ADDR_WIDTH-1:0];
            end
          end
        endcase
      end
    end else if (MEM_ACK) begin
      state_d   = S_IDLE;
      mem_req_d = 1'b0;
      case (pend_q)
        OP_CALL: begin
          sp_d = sp_dec;
          pc_d = tgt_q;
        end
        OP_PUSH: begin
          sp_d = sp_dec;
          pc_d = pc1;
        end
        OP_POP: begin
          sp_d        = sp_inc;
          pc_d        = pc1;
          pop_data_d  = MEM_RDATA;
          pop_valid_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= S_IDLE;
      pend_q      <= OP_NOP;
      pc_q        <= RESET_PC;
      sp_q        <= RESET_SP;
      tgt_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pop_data_q  <= '0;
      pop_valid_q <= 1'b0;
      stk_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pc_q        <= pc_d;
      sp_q        <= sp_d;
      tgt_q       <= tgt_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      pop_data_q  <= pop_data_d;
      pop_valid_q <= pop_valid_d;
      stk_err_q   <= stk_err_d;
    end
  end

  assign PC        = pc_q;
  assign SP        = sp_q;
  assign MEM_REQ   = mem_req_q;
  assign MEM_WE    = mem_we_q;
  assign MEM_ADDR  = mem_addr_q;
  assign MEM_WDATA = mem_wdata_q;
  assign POP_DATA  = pop_data_q;
  assign POP_VALID = pop_valid_q;
  assign STK_ERR   = stk_err_q;

endmodule

// File: tb/tb_pc_sp_unit.sv
// Bench for pc_sp_unit: directed scenarios then random command streams, checked
// against a stack-as-queue reference model; a small stack limit exercises overflow.
module tb_pc_sp_unit;
  localparam logic [31:0] RST_PC = 32'h0000_1000;
  localparam logic [31:0] RST_SP = 32'h03FF_FFFF;
  localparam logic [31:0] LIMIT  = 32'h03FF_FFF8;
  localparam logic [31:0] AMASK  = 32'h03FF_FFFF;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        CMD_VALID = 1'b0;
  logic        CMD_READY;
  logic [2:0]  CMD_OP = 3'd0;
  logic [31:0] IMM = '0, REG_VAL = '0;
  logic        ZERO = 1'b0;
  logic [31:0] PC, SP;
  logic        MEM_REQ, MEM_WE;
  logic [25:0] MEM_ADDR;
  logic [31:0] MEM_WDATA;
  logic [31:0] MEM_RDATA = '0;
  logic        MEM_ACK = 1'b0;
  logic [31:0] POP_DATA;
  logic        POP_VALID, STK_ERR;

  pc_sp_unit #(
    .DATA_WIDTH(32), .ADDR_WIDTH(26), .RESET_PC(RST_PC), .RESET_SP(RST_SP),
    .STACK_LIMIT(LIMIT)
  ) dut (
    .CLK(CLK), .RST(RST), .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_OP(CMD_OP), .IMM(IMM), .REG_VAL(REG_VAL), .ZERO(ZERO), .PC(PC), .SP(SP),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA),
    .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK), .POP_DATA(POP_DATA),
    .POP_VALID(POP_VALID), .STK_ERR(STK_ERR)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: architectural PC/SP, sticky error, and the stack as a queue.
  logic [31:0] pc_m, sp_m, popd_m;
  logic        err_m;
  logic [31:0] stack_m[$];
  logic [31:0] mem[logic [25:0]];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b0;
    CMD_VALID = 1'b0;
    MEM_ACK = 1'b0;
    tick();
    check("rst_ready_low", CMD_READY, 0);
    check("rst_pc", PC, RST_PC);
    check("rst_sp", SP, RST_SP);
    check("rst_req", MEM_REQ, 0);
    check("rst_addr", MEM_ADDR, 0);
    check("rst_err", STK_ERR, 0);
    check("rst_popv", POP_VALID, 0);
    RST = 1'b1;
    #1;
    check("rst_ready_high", CMD_READY, 1);
    pc_m = RST_PC;
    sp_m = RST_SP;
    popd_m = '0;
    err_m = 1'b0;
    stack_m.delete();
  endtask

  // lat < 0 picks a random ack delay
  task automatic do_cmd(input logic [2:0] op, input logic [31:0] imm,
                        input logic [31:0] rv, input logic z, input int lat);
    logic [31:0] pc1, tgt, exp_wd, exp_pop;
    logic [25:0] exp_addr;
    logic        is_mem, exp_we;
    int          w;
    pc1 = pc_m + 1;
    tgt = (pc1 & ~AMASK) | (imm & AMASK);
    is_mem = 1'b0;
    exp_we = 1'b0;
    exp_wd = '0;
    exp_pop = '0;
    exp_addr = '0;
    w = (lat < 0) ? int'($urandom_range(0, 4)) : lat;

    check("cmd_ready", CMD_READY, 1);
    CMD_VALID = 1'b1;
    CMD_OP = op;
    IMM = imm;
    REG_VAL = rv;
    ZERO = z;
    tick();
    CMD_VALID = 1'b0;
    IMM = $urandom;
    REG_VAL = $urandom;

    case (op)
      3'd0: pc_m = pc1;
      3'd1: pc_m = z ? pc1 + imm : pc1;
      3'd2: pc_m = !z ? pc1 + imm : pc1;
      3'd3: pc_m = tgt;
      3'd4: pc_m = rv;
      3'd5, 3'd6: begin
        if (sp_m < LIMIT) begin
          err_m = 1'b1;
          pc_m = pc1;
        end else begin
          is_mem = 1'b1;
          exp_we = 1'b1;
          exp_addr = sp_m[25:0];
          exp_wd = (op == 3'd5) ? pc1 : rv;
          pc_m = (op == 3'd5) ? tgt : pc1;
          sp_m = sp_m - 1;
          stack_m.push_back(exp_wd);
        end
      end
      default: begin
        if (sp_m == RST_SP) begin
          err_m = 1'b1;
          pc_m = pc1;
        end else begin
          is_mem = 1'b1;
          exp_addr = 26'(sp_m + 1);
          exp_pop = stack_m.pop_back();
          sp_m = sp_m + 1;
          pc_m = pc1;
        end
      end
    endcase

    if (is_mem) begin
      check("req_raised", MEM_REQ, 1);
      check("mem_we", MEM_WE, exp_we);
      check("mem_addr", MEM_ADDR, exp_addr);
      if (exp_we) check("mem_wdata", MEM_WDATA, exp_wd);
      check("busy_ready", CMD_READY, 0);
      for (int i = 0; i < w; i++) begin
        CMD_VALID = 1'($urandom_range(0, 1));
        CMD_OP = 3'($urandom_range(0, 7));
        tick();
        check("req_held", MEM_REQ, 1);
        check("addr_held", MEM_ADDR, exp_addr);
      end
      if (exp_we) mem[MEM_ADDR] = MEM_WDATA;
      else MEM_RDATA = mem.exists(MEM_ADDR) ? mem[MEM_ADDR] : $urandom;
      MEM_ACK = 1'b1;
      tick();
      MEM_ACK = 1'b0;
      CMD_VALID = 1'b0;
      check("req_dropped", MEM_REQ, 0);
      check("popv_after_ack", POP_VALID, !exp_we);
      if (!exp_we) begin
        popd_m = exp_pop;
        check("pop_data", POP_DATA, popd_m);
      end
      check("pc_mem", PC, pc_m);
      check("sp_mem", SP, sp_m);
      check("ready_after_ack", CMD_READY, 1);
      if (!exp_we) begin
        tick();
        check("popv_pulse_end", POP_VALID, 0);
      end
    end else begin
      check("no_req", MEM_REQ, 0);
      check("no_popv", POP_VALID, 0);
      check("pc", PC, pc_m);
      check("sp", SP, sp_m);
      check("pop_data_hold", POP_DATA, popd_m);
    end
    check("stk_err", STK_ERR, err_m);
  endtask

  initial begin
    logic [2:0] op;
    do_reset();

    do_cmd(3'd1, 32'hFFFF_FFFC, 0, 1'b1, 0);
    check("beq_taken", PC, 32'h0000_0FFD);
    do_cmd(3'd2, 32'hFFFF_FFFC, 0, 1'b1, 0);
    check("bne_not_taken", PC, 32'h0000_0FFE);
    do_cmd(3'd3, 32'hFC00_1234, 0, 1'b0, 0);
    check("jmp_pc", PC, 32'h0000_1234);

    do_reset();
    do_cmd(3'd5, 32'h0000_2000, 0, 1'b0, 3);
    check("call_pc", PC, 32'h0000_2000);
    check("call_sp", SP, 32'h03FF_FFFE);
    check("call_mem", mem[26'h3FF_FFFF], 32'h0000_1001);

    do_reset();
    do_cmd(3'd6, 0, 32'hDEAD_BEEF, 1'b0, 2);
    do_cmd(3'd7, 0, 0, 1'b0, 1);
    check("pop_deadbeef", POP_DATA, 32'hDEAD_BEEF);
    check("sp_restored", SP, RST_SP);
    do_cmd(3'd7, 0, 0, 1'b0, 0);
    check("underflow_err", STK_ERR, 1);

    do_reset();
    for (int i = 0; i < 8; i++) do_cmd(3'd6, 0, $urandom, 1'b0, -1);
    check("sp_at_floor", SP, LIMIT - 1);
    do_cmd(3'd5, 32'h0000_0777, 0, 1'b0, 0);
    check("overflow_err", STK_ERR, 1);
    check("overflow_sp", SP, LIMIT - 1);

    // Reset while a push is waiting on memory; the late ack must be ignored.
    do_reset();
    CMD_VALID = 1'b1;
    CMD_OP = 3'd6;
    REG_VAL = 32'h1234_5678;
    tick();
    CMD_VALID = 1'b0;
    check("midop_req", MEM_REQ, 1);
    RST = 1'b0;
    tick();
    RST = 1'b1;
    #1;
    check("midrst_req", MEM_REQ, 0);
    check("midrst_pc", PC, RST_PC);
    check("midrst_sp", SP, RST_SP);
    check("midrst_ready", CMD_READY, 1);
    MEM_ACK = 1'b1;
    tick();
    MEM_ACK = 1'b0;
    check("late_ack_pc", PC, RST_PC);
    check("late_ack_sp", SP, RST_SP);
    check("late_ack_req", MEM_REQ, 0);
    pc_m = RST_PC;
    sp_m = RST_SP;
    popd_m = '0;
    err_m = 1'b0;
    stack_m.delete();

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) do_reset();
      op = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(6, 7))
                                       : 3'($urandom_range(0, 7));
      do_cmd(op, ($urandom_range(0, 1) == 1) ? 32'($urandom_range(0, 15)) - 32'd8 : $urandom,
             $urandom, 1'($urandom_range(0, 1)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
